// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, IF/ID register, redirect flush and halt.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
//
// state | meaning
// RUN   | fetching whenever the IF/ID slot is free
// HALT  | no fetches, PC frozen, slot drains on id_ready

module fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 256,
  parameter int RESET_PC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_out,
  input  logic [31:0] imem_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        halted
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]        state_q,    state_d;
  logic [ADDR_W-1:0] pc_q,       pc_d;
  logic              id_valid_q, id_valid_d;
  logic [31:0]       id_instr_q, id_instr_d;
  logic [ADDR_W-1:0] id_pc_q,    id_pc_d;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
`endif

  logic [ADDR_W-1:0] redirect_tgt;
  logic [ADDR_W-1:0] pc_inc;
  logic              slot_free;
  logic              unused_redirect_hi;

  // Targets are taken modulo DEPTH; the discarded upper bits raise no flag.
  assign redirect_tgt       = redirect_pc[ADDR_W-1:0];
  assign unused_redirect_hi = ^redirect_pc[31:ADDR_W];
  assign pc_inc    = (pc_q == ADDR_W'(DEPTH - 1)) ? '0 : pc_q + ADDR_W'(1);
  assign slot_free = !id_valid_q || id_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
`ifdef FETCH_PERF_CNT_EN
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
`endif

    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          pc_d       = redirect_tgt;
          id_valid_d = 1'b0;
          if (halt) state_d = ST_HALT;
        end else if (halt) begin
          state_d = ST_HALT;
          if (id_ready) id_valid_d = 1'b0;
        end else if (slot_free) begin
          id_instr_d = imem_data;
          id_pc_d    = pc_q;
          id_valid_d = 1'b1;
          pc_d       = pc_inc;
`ifdef FETCH_PERF_CNT_EN
          fetch_cnt_d = fetch_cnt_q + 32'd1;
`endif
        end else begin
`ifdef FETCH_PERF_CNT_EN
          stall_cnt_d = stall_cnt_q + 32'd1;
`endif
        end
      end
      default: begin
        if (id_ready) id_valid_d = 1'b0;
        // A redirect always loads the PC; only halt=0 lets it resume fetching.
        if (redirect) begin
          pc_d       = redirect_tgt;
          id_valid_d = 1'b0;
          if (!halt) state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pc_q        <= ADDR_W'(RESET_PC);
      id_valid_q  <= 1'b0;
      id_instr_q  <= '0;
      id_pc_q     <= '0;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  assign pc_out   = {{(32-ADDR_W){1'b0}}, pc_q};
  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc    = {{(32-ADDR_W){1'b0}}, id_pc_q};
  assign halted   = (state_q == ST_HALT);
`ifdef FETCH_PERF_CNT_EN
  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory word i holds 0x100+i.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_out;
  logic [31:0] imem_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  assign imem_data = mem[pc_out[7:0]];

  fetch_unit #(.ADDR_W(8), .DEPTH(256), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_out      (pc_out),
    .imem_data   (imem_data),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count (fetch_count),
    .stall_count (stall_count),
`endif
    .halted      (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    step(); step();
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc got %h expected %h", pc_out, 32'd0); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", id_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b expected 0", halted); end
    checks++; if (id_instr !== 32'd0 || id_pc !== 32'd0) begin errors++; $display("FAIL reset_slot got %h/%h expected 0/0", id_instr, id_pc); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d expected 0/0", fetch_count, stall_count); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (id_valid !== 1'b1 || id_instr !== 32'h100 + 32'(k) || id_pc !== 32'(k) || pc_out !== 32'(k + 1)) begin
        errors++;
        $display("FAIL seq_%0d got v=%b instr=%h pc=%h pc_out=%h expected v=1 instr=%h pc=%h pc_out=%h",
                 k, id_valid, id_instr, id_pc, pc_out, 32'h100 + 32'(k), 32'(k), 32'(k + 1));
      end
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (id_valid !== 1'b1 || id_instr !== 32'h102 || id_pc !== 32'd2 || pc_out !== 32'd3) begin
        errors++;
        $display("FAIL stall_%0d got v=%b instr=%h pc=%h pc_out=%h expected v=1 instr=102 pc=2 pc_out=3",
                 k, id_valid, id_instr, id_pc, pc_out);
      end
    end
    id_ready = 1'b1;
    step();
    checks++;
    if (id_instr !== 32'h103 || id_pc !== 32'd3 || pc_out !== 32'd4) begin
      errors++;
      $display("FAIL stall_resume got instr=%h pc=%h pc_out=%h expected instr=103 pc=3 pc_out=4", id_instr, id_pc, pc_out);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (stall_count !== 32'd3) begin errors++; $display("FAIL stall_count got %0d expected 3", stall_count); end
    checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL fetch_count got %0d expected 4", fetch_count); end
`endif
  endtask

  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h105;
    step();
    redirect = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || pc_out !== 32'd5) begin
      errors++; $display("FAIL redirect_bubble got v=%b pc_out=%h expected v=0 pc_out=5", id_valid, pc_out);
    end
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'd5 || id_instr !== 32'h105 || pc_out !== 32'd6) begin
      errors++; $display("FAIL redirect_target got v=%b instr=%h pc=%h pc_out=%h expected v=1 instr=105 pc=5 pc_out=6",
                         id_valid, id_instr, id_pc, pc_out);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'd254; exp_pc[1] = 32'd255; exp_pc[2] = 32'd0; exp_pc[3] = 32'd1;
    redirect = 1'b1; redirect_pc = 32'd254;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (id_valid !== 1'b1 || id_pc !== exp_pc[k] || id_instr !== 32'h100 + exp_pc[k] || pc_out > 32'd255) begin
        errors++;
        $display("FAIL wrap_%0d got v=%b pc=%h instr=%h pc_out=%h expected v=1 pc=%h instr=%h pc_out<=ff",
                 k, id_valid, id_pc, id_instr, pc_out, exp_pc[k], 32'h100 + exp_pc[k]);
      end
    end
  endtask

  task automatic test_halt();
    id_ready = 1'b0; halt = 1'b1;
    step();
    halt = 1'b0;
    checks++;
    if (halted !== 1'b1 || id_valid !== 1'b1 || id_pc !== 32'd1 || pc_out !== 32'd2) begin
      errors++; $display("FAIL halt_enter got h=%b v=%b pc=%h pc_out=%h expected h=1 v=1 pc=1 pc_out=2", halted, id_valid, id_pc, pc_out);
    end
    step();
    checks++;
    if (halted !== 1'b1 || id_valid !== 1'b1 || pc_out !== 32'd2) begin
      errors++; $display("FAIL halt_hold got h=%b v=%b pc_out=%h expected h=1 v=1 pc_out=2", halted, id_valid, pc_out);
    end
    id_ready = 1'b1;
    step();
    checks++;
    if (halted !== 1'b1 || id_valid !== 1'b0 || pc_out !== 32'd2) begin
      errors++; $display("FAIL halt_drain got h=%b v=%b pc_out=%h expected h=1 v=0 pc_out=2", halted, id_valid, pc_out);
    end
    redirect = 1'b1; redirect_pc = 32'd0;
    step();
    redirect = 1'b0;
    checks++;
    if (halted !== 1'b0 || id_valid !== 1'b0 || pc_out !== 32'd0) begin
      errors++; $display("FAIL halt_resume got h=%b v=%b pc_out=%h expected h=0 v=0 pc_out=0", halted, id_valid, pc_out);
    end
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'd0 || id_instr !== 32'h100) begin
      errors++; $display("FAIL halt_refetch got v=%b pc=%h instr=%h expected v=1 pc=0 instr=100", id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_redirect_halt();
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (pc_out !== 32'd6) begin errors++; $display("FAIL rh_setup got pc_out=%h expected 6", pc_out); end
    redirect = 1'b1; halt = 1'b1; redirect_pc = 32'd2;
    step();
    redirect = 1'b0; halt = 1'b0;
    checks++;
    if (pc_out !== 32'd2 || id_valid !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL rh_enter got pc_out=%h v=%b h=%b expected pc_out=2 v=0 h=1", pc_out, id_valid, halted);
    end
    step(); step();
    checks++;
    if (pc_out !== 32'd2 || id_valid !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL rh_idle got pc_out=%h v=%b h=%b expected pc_out=2 v=0 h=1", pc_out, id_valid, halted);
    end
    redirect = 1'b1; redirect_pc = 32'd7;
    step();
    redirect = 1'b0;
    checks++;
    if (halted !== 1'b0 || pc_out !== 32'd7 || id_valid !== 1'b0) begin
      errors++; $display("FAIL rh_resume got h=%b pc_out=%h v=%b expected h=0 pc_out=7 v=0", halted, pc_out, id_valid);
    end
    step();
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'd7 || id_instr !== 32'h107) begin
      errors++; $display("FAIL rh_fetch got v=%b pc=%h instr=%h expected v=1 pc=7 instr=107", id_valid, id_pc, id_instr);
    end
  endtask

  task automatic test_reset_mid_stall();
    id_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    checks++;
    if (id_valid !== 1'b0 || pc_out !== 32'd0 || id_instr !== 32'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL reset_stall got v=%b pc_out=%h instr=%h h=%b expected v=0 pc_out=0 instr=0 h=0", id_valid, pc_out, id_instr, halted);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (fetch_count !== 32'd0 || stall_count !== 32'd0) begin errors++; $display("FAIL reset_stall_counters got %0d/%0d expected 0/0", fetch_count, stall_count); end
`endif
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + 32'(i);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_redirect_halt();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the program counter into the combinational instruction memory and captures the returned word into the IF/ID pipeline register. It owns PC sequencing (increment, wrap, redirect), back-pressure from decode, flush on redirect, and a halt state. It sits directly upstream of the instruction memory and directly downstream of branch resolution.

## Interface
- ADDR_W, 8, word-address bits used by instruction memory.
- DEPTH, 256, number of instruction words; must equal 2**ADDR_W.
- RESET_PC, 0, word address loaded into the PC on reset.

- clk  in  1  rising-edge clock; all state updates here.
- rst_n  in  1  synchronous active-low reset.
- pc_out  out  32  word index to instruction memory; bits [31:ADDR_W] always 0.
- imem_data  in  32  instruction word returned combinationally for pc_out.
- id_valid  out  1  IF/ID slot holds a valid instruction.
- id_ready  in  1  decode accepts the slot this cycle.
- id_instr  out  32  captured instruction.
- id_pc  out  32  word address id_instr was fetched from.
- redirect  in  1  branch/jump taken; load redirect_pc and flush.
- redirect_pc  in  32  target word address; only bits [ADDR_W-1:0] are used.
- halt  in  1  stop fetching.
- halted  out  1  unit is in HALT state.
- fetch_count  out  32  present only with FETCH_PERF_CNT_EN.
- stall_count  out  32  present only with FETCH_PERF_CNT_EN.

## Operation
- Reset (rst_n=0 at clk edge): pc=RESET_PC, state=RUN, id_valid=0, id_instr=0, id_pc=0, halted=0, counters=0.
- pc_out is the PC register directly; no combinational path from any input to pc_out.
- Slot free = !id_valid || id_ready.
- States: RUN, HALT.
- RUN, priority order per cycle:
  - redirect=1: pc <= {0, redirect_pc[ADDR_W-1:0]}; id_valid <= 0 (flush, regardless of id_ready). If halt=1 also, next state HALT, else stay RUN.
  - halt=1: next state HALT; pc frozen; no new capture; if id_ready, id_valid <= 0, else slot held.
  - slot free: id_instr <= imem_data, id_pc <= pc, id_valid <= 1, pc <= (pc+1) mod DEPTH.
  - otherwise (stall): pc, id_instr, id_pc, id_valid held.
- HALT: halted=1; no fetches; pc frozen; id_valid clears when id_ready=1, otherwise slot held. redirect=1 with halt=0 → pc <= redirect_pc (masked), id_valid <= 0, state RUN. halt=1 keeps HALT even with redirect (pc still loaded).
- Wrap-around: pc=DEPTH-1 captured → next pc=0; id_pc=DEPTH-1.
- Out-of-range redirect_pc: upper bits discarded (modulo DEPTH), no error flag.

## Timing
- Fetch latency: word at pc_out appears on id_instr/id_valid one cycle later.
- First cycle after rst_n rises: pc_out=RESET_PC; next edge captures it (id_valid=1).
- Redirect: one bubble cycle (id_valid=0), then target instruction valid on following edge; redirect penalty = 1 cycle.
- Stall holds all outputs stable for as many cycles as id_ready=0 with id_valid=1.
- halted asserts on the edge after halt is sampled and deasserts on the edge that samples the resuming redirect.
- Reset mid-stall/mid-halt discards slot contents immediately at that edge.

## Configuration
- FETCH_PERF_CNT_EN defined: fetch_count increments on each capture (id_valid loaded with 1); stall_count increments each RUN cycle with id_valid=1, id_ready=0, redirect=0, halt=0. Both wrap modulo 2**32, reset to 0.
- Undefined: both ports and their registers are absent; all other behaviour identical.

## Test plan
- Reset release with RESET_PC=0, id_ready=1, memory words 0..7 = 0x100+i → id_instr sequence 0x100,0x101,… with id_pc 0,1,…, one per cycle, first valid one cycle after reset release.
- Hold id_ready=0 for 3 cycles while id_valid=1 at pc_out=3 → id_instr=0x102, id_pc=2 held, pc_out=3 held; resume → 0x103 next; stall_count=3 with FETCH_PERF_CNT_EN.
- redirect=1, redirect_pc=0x1_05 at pc=4 → next cycle id_valid=0, pc_out=5; following cycle id_pc=5, id_instr=memword[5].
- Run from pc=254 with id_ready=1 → id_pc 254,255,0,1; pc_out never exceeds 255.
- halt=1 for one cycle, id_ready=0 → halted=1, slot held, pc frozen; id_ready=1 → id_valid=0; redirect to 0 → halted=0, fetch resumes at 0.
- redirect and halt asserted together at pc=6, target 2 → pc_out=2, id_valid=0, halted=1; no fetch until a later redirect with halt=0.
